regfile_writeback: RTL and testbench

Write-back stage that owns the single write port of the 32x32 register file. It merges single-cycle ALU results with results from the multi-cycle multiply/divide unit (MDU), and buffers MDU results in a small FIFO. It drives one registered write per cycle and keeps a pending-register scoreboard that the decoder queries to stall on outstanding MDU destinations.

---
 rtl/regfile_writeback.sv | 142 ++++++++++++++
 tb/tb_regfile_writeback.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Purpose: write-back stage that owns the register-file write port. It merges ALU results with FIFO-buffered MDU results and keeps a pending-destination scoreboard.
// Latency: ALU writes take 1 edge. MDU writes take at least 2 edges through the FIFO, or 1 edge on the idle bypass path when WB_BYPASS_EN is defined.
// Backpressure: ALU writes are always accepted and have priority. mdu_ready drops while the FIFO is full or while rst is high.
module regfile_writeback #(
    parameter int W     = 5,
    parameter int D     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [W-1:0]             alu_wa,
    input  logic [D-1:0]             alu_data,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [W-1:0]             mdu_wa,
    input  logic [D-1:0]             mdu_data,
    input  logic                     issue_valid,
    input  logic [W-1:0]             issue_wa,
    input  logic [W-1:0]             chk_ra1,
    input  logic [W-1:0]             chk_ra2,
    output logic                     busy1,
    output logic                     busy2,
    output logic                     rf_we,
    output logic [W-1:0]             rf_wa,
    output logic [D-1:0]             rf_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PW   = $clog2(DEPTH);
    localparam int NREG = 1 << W;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [W-1:0]    r_fifo_wa   [DEPTH];
    logic [D-1:0]    r_fifo_data [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic [NREG-1:0] r_pending;
    logic            r_rf_we;
    logic [W-1:0]    r_rf_wa;
    logic [D-1:0]    r_rf_data;

    logic            w_mdu_ready;
    logic            w_empty;
    logic            w_alu_wr;
    logic            w_pop;
    logic            w_xfer;
    logic            w_bypass;
    logic            w_push;
    logic [W-1:0]    w_head_wa;
    logic [D-1:0]    w_head_data;
    logic [NREG-1:0] w_pending_nxt;

    // Handshake and arbitration. A zero-destination ALU result does not claim the port, so the FIFO head can pop in that cycle.
    always_comb begin
        w_mdu_ready = !rst && (r_count < FULL);
        w_empty     = (r_count == '0);
        w_alu_wr    = alu_valid && (alu_wa != '0);
        w_pop       = !w_alu_wr && !w_empty;
        w_xfer      = mdu_valid && w_mdu_ready;
`ifdef WB_BYPASS_EN
        w_bypass    = w_xfer && w_empty && !alu_valid && (mdu_wa != '0);
`else
        w_bypass    = 1'b0;
`endif
        w_push      = w_xfer && (mdu_wa != '0) && !w_bypass;
        w_head_wa   = r_fifo_wa[r_rd_ptr];
        w_head_data = r_fifo_data[r_rd_ptr];
    end

    // Scoreboard next state. Clears are applied first so that a same-cycle re-issue of the same register wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) begin
            w_pending_nxt[w_head_wa] = 1'b0;
        end
        if (w_bypass) begin
            w_pending_nxt[mdu_wa] = 1'b0;
        end
        if (issue_valid && (issue_wa != '0)) begin
            w_pending_nxt[issue_wa] = 1'b1;
        end
    end

    // FIFO payload storage. It holds data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_wa[r_wr_ptr]   <= mdu_wa;
            r_fifo_data[r_wr_ptr] <= mdu_data;
        end
    end

    // Control state: FIFO pointers and count, scoreboard, and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pending <= '0;
            r_rf_we   <= 1'b0;
            r_rf_wa   <= '0;
            r_rf_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_pending <= w_pending_nxt;
            if (w_alu_wr) begin
                r_rf_we   <= 1'b1;
                r_rf_wa   <= alu_wa;
                r_rf_data <= alu_data;
            end else if (w_pop) begin
                r_rf_we   <= 1'b1;
                r_rf_wa   <= w_head_wa;
                r_rf_data <= w_head_data;
            end else if (w_bypass) begin
                r_rf_we   <= 1'b1;
                r_rf_wa   <= mdu_wa;
                r_rf_data <= mdu_data;
            end else begin
                r_rf_we   <= 1'b0;
            end
        end
    end

    assign mdu_ready  = w_mdu_ready;
    assign busy1      = r_pending[chk_ra1] && (chk_ra1 != '0);
    assign busy2      = r_pending[chk_ra2] && (chk_ra2 != '0);
    assign rf_we      = r_rf_we;
    assign rf_wa      = r_rf_wa;
    assign rf_data    = r_rf_data;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_wa;
    logic [31:0] alu_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_wa;
    logic [31:0] mdu_data;
    logic        issue_valid;
    logic [4:0]  issue_wa;
    logic [4:0]  chk_ra1;
    logic [4:0]  chk_ra2;
    logic        busy1;
    logic        busy2;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_data;
    logic [2:0]  fifo_count;

    regfile_writeback #(.W(5), .D(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_data(alu_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_wa(mdu_wa), .mdu_data(mdu_data),
        .issue_valid(issue_valid), .issue_wa(issue_wa),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .busy1(busy1), .busy2(busy2),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_data(rf_data), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] d;
    } exp_t;

    // Reference model: the queue holds the MDU results waiting for the port, and the bit array holds the outstanding destinations.
    exp_t        exp_q[$];
    logic [4:0]  mq_wa[$];
    logic [31:0] mq_d[$];
    bit   [31:0] pend;
    logic [4:0]  last_wa;
    logic [31:0] last_d;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic av, input logic [4:0] awa, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mwa, input logic [31:0] md,
                        input logic iv, input logic [4:0] iwa,
                        input logic [4:0] c1, input logic [4:0] c2);
        exp_t e;
        bit   xfer;
        bit   was_empty;
        bit   byp;
        bit   clr_v;
        logic [4:0] clr_wa;
        @(negedge clk);
        rst = r; alu_valid = av; alu_wa = awa; alu_data = ad;
        mdu_valid = mv; mdu_wa = mwa; mdu_data = md;
        issue_valid = iv; issue_wa = iwa; chk_ra1 = c1; chk_ra2 = c2;
        #1;
        chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, (!r && mq_wa.size() < DEPTH)});
        chk("fifo_count", {29'd0, fifo_count}, mq_wa.size());
        chk("busy1", {31'd0, busy1}, {31'd0, (c1 != 0) && pend[c1]});
        chk("busy2", {31'd0, busy2}, {31'd0, (c2 != 0) && pend[c2]});
        @(posedge clk);
        if (r) begin
            mq_wa.delete(); mq_d.delete();
            pend = '0; last_wa = '0; last_d = '0;
            e = '{we: 1'b0, wa: 5'd0, d: 32'd0};
        end else begin
            xfer      = mv && (mq_wa.size() < DEPTH);
            was_empty = (mq_wa.size() == 0);
            byp       = 0;
`ifdef WB_BYPASS_EN
            byp = xfer && was_empty && !av && (mwa != 0);
`endif
            clr_v = 0; clr_wa = '0;
            e.we = 1'b0;
            if (av && awa != 0) begin
                e.we = 1'b1; last_wa = awa; last_d = ad;
            end else if (!was_empty) begin
                e.we = 1'b1; last_wa = mq_wa.pop_front(); last_d = mq_d.pop_front();
                clr_v = 1; clr_wa = last_wa;
            end else if (byp) begin
                e.we = 1'b1; last_wa = mwa; last_d = md;
                clr_v = 1; clr_wa = mwa;
            end
            if (xfer && mwa != 0 && !byp) begin
                mq_wa.push_back(mwa); mq_d.push_back(md);
            end
            if (clr_v) pend[clr_wa] = 1'b0;
            if (iv && iwa != 0) pend[iwa] = 1'b1;
            e.wa = last_wa; e.d = last_d;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compares the registered write port against the oldest expected record each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
                chk("rf_wa", {27'd0, rf_wa}, {27'd0, e.wa});
                chk("rf_data", rf_data, e.d);
            end
        end
    end

    initial begin
        int alu_pct;
        rst = 1'b1; alu_valid = 0; alu_wa = 0; alu_data = 0;
        mdu_valid = 0; mdu_wa = 0; mdu_data = 0;
        issue_valid = 0; issue_wa = 0; chk_ra1 = 0; chk_ra2 = 0;
        pend = '0; last_wa = '0; last_d = '0;
        repeat (2) @(posedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ALU write, then idle.
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Scoreboard and zero-register filter: issue 7, queue {3,0x11} behind an ALU write, then a zero-destination ALU write lets the head pop.
        step(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 3);
        step(0, 1, 1, 32'h1, 1, 3, 32'h11, 1, 3, 7, 3);
        step(0, 1, 0, 32'h2, 1, 0, 32'h99, 0, 0, 7, 3);
        step(0, 1, 2, 32'h3, 1, 7, 32'h77, 0, 0, 7, 3);
        step(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 3);

        // Fill the FIFO under sustained ALU traffic, then drain it and accept the fifth result.
        for (int i = 0; i < 6; i++)
            step(0, 1, 5'(i + 1), 32'(i), 1, 5'(8 + i), 32'(100 + i), 0, 0, 8, 9);
        for (int i = 0; i < 6; i++)
            step(0, 0, 0, 0, 1, 5'd20, 32'(200 + i), 0, 0, 20, 8);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 20, 0);

        // Reset mid-stream with queued results and pending registers 2 and 9.
        step(0, 1, 1, 1, 1, 2, 32'h22, 1, 2, 2, 9);
        step(0, 1, 1, 2, 1, 9, 32'h99, 1, 9, 2, 9);
        step(0, 1, 1, 3, 1, 4, 32'h44, 0, 0, 2, 9);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 9);
        step(0, 0, 0, 0, 1, 4, 32'h55, 0, 0, 2, 9);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 9);

        // Randomized traffic with phase-dependent ALU load.
        for (int i = 0; i < 2000; i++) begin
            case ((i / 250) % 5)
                0: alu_pct = 10;
                1: alu_pct = 50;
                2: alu_pct = 95;
                3: alu_pct = 0;
                default: alu_pct = 30;
            endcase
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < alu_pct), 5'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 15)),
                 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #2;
        chk("expected_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
